ex_muldiv_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers. It sits beside the ALU in the EX stage of the MIPS pipeline and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply and divide run over several cycles; MFHI/MFLO read `o_hi_E`/`o_lo_E`. It raises a stall to the hazard unit whenever an instruction needs HI/LO or the unit while an operation is still in flight.

---
 rtl/ex_muldiv_unit.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO for the EX stage.
// Shift-add multiply and restoring divide, BITS_PER_CYCLE steps per clock.
module ex_muldiv_unit #(
  parameter int INST_SZ        = 32,
  parameter int MD_OP          = 3,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start_MC,
  input  logic [MD_OP-1:0]   i_md_op_MC,
  input  logic               i_hilo_read_MC,
  input  logic               i_flush_HU,
  input  logic [INST_SZ-1:0] i_operand_a_E,
  input  logic [INST_SZ-1:0] i_operand_b_E,
  output logic [INST_SZ-1:0] o_hi_E,
  output logic [INST_SZ-1:0] o_lo_E,
  output logic               o_busy_E,
  output logic               o_stall_E,
  output logic               o_done_E,
  output logic               o_div_by_zero_E
);

  localparam int N     = INST_SZ / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [MD_OP-1:0] OP_MULT  = MD_OP'(3'd0);
  localparam logic [MD_OP-1:0] OP_MULTU = MD_OP'(3'd1);
  localparam logic [MD_OP-1:0] OP_DIV   = MD_OP'(3'd2);
  localparam logic [MD_OP-1:0] OP_DIVU  = MD_OP'(3'd3);
  localparam logic [MD_OP-1:0] OP_MTHI  = MD_OP'(3'd4);
  localparam logic [MD_OP-1:0] OP_MTLO  = MD_OP'(3'd5);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    FINISH = 2'b10
  } state_t;

  state_t state_r, state_next_s;

  logic [INST_SZ-1:0] hi_r, lo_r;
  logic [INST_SZ-1:0] p_r, q_r, mcand_r, a_raw_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               is_div_r, prod_neg_r, quot_neg_r, rem_neg_r, div_zero_r;
  logic               busy_r, done_r, dbz_r;

  logic               is_mul_s, is_div_s, is_signed_s, is_mthi_s, is_mtlo_s;
  logic               idle_start_s, a_neg_s, b_neg_s;
  logic [INST_SZ-1:0] a_mag_s, b_mag_s, p_step_s, q_step_s, fin_hi_s, fin_lo_s;
  logic [2*INST_SZ-1:0] prod_s;

  // Two's complement negate when neg is set; doubles as absolute value.
  function automatic logic [INST_SZ-1:0] neg_f(input logic [INST_SZ-1:0] v, input logic neg);
    neg_f = neg ? (~v + INST_SZ'(1)) : v;
  endfunction

  function automatic logic [2*INST_SZ-1:0] neg2_f(input logic [2*INST_SZ-1:0] v, input logic neg);
    neg2_f = neg ? (~v + (2*INST_SZ)'(1)) : v;
  endfunction

  // Op decode.
  always_comb begin
    is_mul_s    = 1'b0;
    is_div_s    = 1'b0;
    is_signed_s = 1'b0;
    is_mthi_s   = 1'b0;
    is_mtlo_s   = 1'b0;
    case (i_md_op_MC)
      OP_MULT:  begin is_mul_s = 1'b1; is_signed_s = 1'b1; end
      OP_MULTU: is_mul_s  = 1'b1;
      OP_DIV:   begin is_div_s = 1'b1; is_signed_s = 1'b1; end
      OP_DIVU:  is_div_s  = 1'b1;
      OP_MTHI:  is_mthi_s = 1'b1;
      OP_MTLO:  is_mtlo_s = 1'b1;
      default:  is_mul_s  = 1'b0;
    endcase
  end

  // A flush in IDLE suppresses every start, including MTHI/MTLO.
  assign idle_start_s = i_start_MC & ~i_flush_HU & (state_r == IDLE);
  assign a_neg_s      = is_signed_s & i_operand_a_E[INST_SZ-1];
  assign b_neg_s      = is_signed_s & i_operand_b_E[INST_SZ-1];
  assign a_mag_s      = neg_f(i_operand_a_E, a_neg_s);
  assign b_mag_s      = neg_f(i_operand_b_E, b_neg_s);

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (idle_start_s && (is_mul_s || is_div_s)) state_next_s = BUSY;
        else                                         state_next_s = IDLE;
      end
      BUSY: begin
        if (i_flush_HU)                    state_next_s = IDLE;
        else if (cnt_r == CNT_W'(1))       state_next_s = FINISH;
        else                               state_next_s = BUSY;
      end
      FINISH:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State and busy registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
    end
  end

  // One clock of iteration: {p,q} is the 2W product accumulator for multiply,
  // remainder/quotient pair for divide; mcand holds multiplicand or divisor.
  always_comb begin
    logic [INST_SZ-1:0] p_v, q_v;
    logic [INST_SZ:0]   t_v;
    p_v = p_r;
    q_v = q_r;
    t_v = {(INST_SZ+1){1'b0}};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div_r) begin
        t_v = {p_v, q_v[INST_SZ-1]};
        if (t_v >= {1'b0, mcand_r}) begin
          t_v = t_v - {1'b0, mcand_r};
          q_v = {q_v[INST_SZ-2:0], 1'b1};
        end else begin
          q_v = {q_v[INST_SZ-2:0], 1'b0};
        end
        p_v = t_v[INST_SZ-1:0];
      end else begin
        t_v = {1'b0, p_v} + (q_v[0] ? {1'b0, mcand_r} : {(INST_SZ+1){1'b0}});
        {p_v, q_v} = {t_v, q_v[INST_SZ-1:1]};
      end
    end
    p_step_s = p_v;
    q_step_s = q_v;
  end

  // Sign correction; a zero divisor yields all-ones quotient and the raw dividend.
  always_comb begin
    prod_s = neg2_f({p_r, q_r}, prod_neg_r);
    if (!is_div_r) begin
      fin_hi_s = prod_s[2*INST_SZ-1:INST_SZ];
      fin_lo_s = prod_s[INST_SZ-1:0];
    end else if (div_zero_r) begin
      fin_hi_s = a_raw_r;
      fin_lo_s = {INST_SZ{1'b1}};
    end else begin
      fin_hi_s = neg_f(p_r, rem_neg_r);
      fin_lo_s = neg_f(q_r, quot_neg_r);
    end
  end

  // Datapath, HI/LO and status pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hi_r       <= {INST_SZ{1'b0}};
      lo_r       <= {INST_SZ{1'b0}};
      p_r        <= {INST_SZ{1'b0}};
      q_r        <= {INST_SZ{1'b0}};
      mcand_r    <= {INST_SZ{1'b0}};
      a_raw_r    <= {INST_SZ{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      is_div_r   <= 1'b0;
      prod_neg_r <= 1'b0;
      quot_neg_r <= 1'b0;
      rem_neg_r  <= 1'b0;
      div_zero_r <= 1'b0;
      done_r     <= 1'b0;
      dbz_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (idle_start_s && (is_mul_s || is_div_s)) begin
            p_r        <= {INST_SZ{1'b0}};
            q_r        <= is_div_s ? a_mag_s : b_mag_s;
            mcand_r    <= is_div_s ? b_mag_s : a_mag_s;
            a_raw_r    <= i_operand_a_E;
            is_div_r   <= is_div_s;
            prod_neg_r <= a_neg_s ^ b_neg_s;
            quot_neg_r <= a_neg_s ^ b_neg_s;
            rem_neg_r  <= a_neg_s;
            div_zero_r <= is_div_s & (i_operand_b_E == {INST_SZ{1'b0}});
            cnt_r      <= CNT_W'(N);
          end else if (idle_start_s && is_mthi_s) begin
            hi_r <= i_operand_a_E;
          end else if (idle_start_s && is_mtlo_s) begin
            lo_r <= i_operand_a_E;
          end
        end
        BUSY: begin
          if (i_flush_HU) begin
            cnt_r <= {CNT_W{1'b0}};
          end else begin
            p_r   <= p_step_s;
            q_r   <= q_step_s;
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        FINISH: begin
          if (!i_flush_HU) begin
            hi_r   <= fin_hi_s;
            lo_r   <= fin_lo_s;
            done_r <= 1'b1;
            dbz_r  <= div_zero_r;
          end
        end
        default: cnt_r <= {CNT_W{1'b0}};
      endcase
    end
  end

  assign o_hi_E          = hi_r;
  assign o_lo_E          = lo_r;
  assign o_busy_E        = busy_r;
  assign o_done_E        = done_r;
  assign o_div_by_zero_E = dbz_r;
  assign o_stall_E       = busy_r & (i_start_MC | i_hilo_read_MC);

endmodule
